// File: rtl/wave_buffer.sv
// Acquisition memory for one waveform frame: circular capture with pre-trigger history,
// level/edge trigger, post-trigger fill, then looping oldest-first replay to the DAC.
//
// Ports:
//   in_clk      system clock, all logic on its rising edge
//   reset       asynchronous active-high reset
//   sample_en   one-cycle strobe: write adc_data (PRE/ARMED/POST)
//   resume_en   one-cycle strobe: emit next replay sample (READ)
//   adc_data    unsigned ADC sample
//   arm         one-cycle strobe: restart acquisition, highest priority
//   trig_level  unsigned trigger threshold
//   trig_edge   0 rising, 1 falling
//   dac_data    registered replay sample, held between pulses
//   dac_valid   one-cycle pulse: dac_data updated
//   frame_done  one-cycle pulse with the last sample of a replay pass
//   state       0 IDLE, 1 PRE, 2 ARMED, 3 POST, 4 READ
module wave_buffer #(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int PRE_SAMPLES = 64
) (
  input  logic          in_clk,
  input  logic          reset,
  input  logic          sample_en,
  input  logic          resume_en,
  input  logic [DW-1:0] adc_data,
  input  logic          arm,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_edge,
  output logic [DW-1:0] dac_data,
  output logic          dac_valid,
  output logic          frame_done,
  output logic [2:0]    state
);

  localparam int DEPTH = 1 << AW;

  localparam logic [AW-1:0] PRE_N    = AW'(PRE_SAMPLES);
  localparam logic [AW-1:0] POST_N   = AW'(DEPTH - PRE_SAMPLES);
  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE      = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] prev_q, prev_d;
  logic [DW-1:0] dac_data_q, dac_data_d;
  logic          dac_valid_q, dac_valid_d;
  logic          frame_done_q, frame_done_d;

  logic [DW-1:0] mem [DEPTH];

  logic          wr_en;
  logic [AW-1:0] wr_inc;
  logic          trig_hit;

  assign wr_inc = wr_ptr_q + ONE;

  // Level crossing relative to the previously written sample.
  always_comb begin
    if (trig_edge) begin
      trig_hit = (prev_q > trig_level) &&
                 (adc_data <= trig_level);
    end else begin
      trig_hit = (prev_q < trig_level) &&
                 (adc_data >= trig_level);
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rd_idx_d     = rd_idx_q;
    cnt_d        = cnt_q;
    prev_d       = prev_q;
    dac_data_d   = dac_data_q;
    dac_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    wr_en        = 1'b0;

    if (arm) begin
      state_d  = S_PRE;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        S_PRE: begin
          if (sample_en) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + ONE;
            if (cnt_d == PRE_N) begin
              state_d = S_ARMED;
            end
          end
        end
        S_ARMED: begin
          if (sample_en) begin
            wr_en = 1'b1;
            if (trig_hit) begin
              // Trigger sample is post sample 1.
              cnt_d = ONE;
              if (POST_N == ONE) begin
                state_d  = S_READ;
                rd_ptr_d = wr_inc;
                rd_idx_d = '0;
              end else begin
                state_d = S_POST;
              end
            end
          end
        end
        S_POST: begin
          if (sample_en) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + ONE;
            if (cnt_d == POST_N) begin
              // Frame is full: the next write slot holds the oldest sample.
              state_d  = S_READ;
              rd_ptr_d = wr_inc;
              rd_idx_d = '0;
            end
          end
        end
        S_READ: begin
          if (resume_en) begin
            dac_data_d   = mem[rd_ptr_q];
            dac_valid_d  = 1'b1;
            frame_done_d = (rd_idx_q == IDX_LAST);
            rd_ptr_d     = rd_ptr_q + ONE;
            rd_idx_d     = rd_idx_q + ONE;
          end
        end
        default: begin
        end
      endcase

      if (wr_en) begin
        wr_ptr_d = wr_inc;
        prev_d   = adc_data;
      end
    end
  end

  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_idx_q     <= '0;
      cnt_q        <= '0;
      prev_q       <= '0;
      dac_data_q   <= '0;
      dac_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_idx_q     <= rd_idx_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      dac_data_q   <= dac_data_d;
      dac_valid_q  <= dac_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Sample RAM keeps its contents through reset.
  always_ff @(posedge in_clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= adc_data;
    end
  end

  assign dac_data   = dac_data_q;
  assign dac_valid  = dac_valid_q;
  assign frame_done = frame_done_q;
  assign state      = state_q;

endmodule

// File: tb/tb_wave_buffer.sv
// Testbench for wave_buffer: directed scenarios plus random traffic
// checked against a history-queue reference model.
module tb_wave_buffer;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int PRE   = 4;

  localparam int P_IDLE  = 0;
  localparam int P_PRE   = 1;
  localparam int P_ARMED = 2;
  localparam int P_POST  = 3;
  localparam int P_READ  = 4;

  logic          in_clk = 1'b0;
  logic          reset;
  logic          sample_en;
  logic          resume_en;
  logic [DW-1:0] adc_data;
  logic          arm;
  logic [DW-1:0] trig_level;
  logic          trig_edge;
  logic [DW-1:0] dac_data;
  logic          dac_valid;
  logic          frame_done;
  logic [2:0]    state;

  int total = 0;
  int bad   = 0;

  wave_buffer #(
    .DW(DW),
    .AW(AW),
    .PRE_SAMPLES(PRE)
  ) dut (
    .in_clk(in_clk),
    .reset(reset),
    .sample_en(sample_en),
    .resume_en(resume_en),
    .adc_data(adc_data),
    .arm(arm),
    .trig_level(trig_level),
    .trig_edge(trig_edge),
    .dac_data(dac_data),
    .dac_valid(dac_valid),
    .frame_done(frame_done),
    .state(state)
  );

  always #25 in_clk = ~in_clk;

  // Reference model: keeps every sample written since arm;
  // the frame is simply the last DEPTH of them.
  int         m_phase;
  logic [7:0] m_hist[$];
  logic [7:0] m_frame[DEPTH];
  int         m_cnt;
  int         m_ridx;
  logic [7:0] m_prev;
  logic [7:0] m_data;
  bit         m_valid;
  bit         m_fd;

  function automatic void model_reset();
    m_phase = P_IDLE;
    m_hist.delete();
    m_cnt   = 0;
    m_ridx  = 0;
    m_prev  = 0;
    m_data  = 0;
    m_valid = 0;
    m_fd    = 0;
  endfunction

  function automatic void model_step(bit a, bit se, bit re, logic [7:0] d);
    bit hit;
    m_valid = 0;
    m_fd    = 0;
    if (a) begin
      m_phase = P_PRE;
      m_hist.delete();
      m_cnt = 0;
      return;
    end
    if (m_phase == P_READ) begin
      if (re) begin
        m_data  = m_frame[m_ridx];
        m_valid = 1;
        m_fd    = (m_ridx == DEPTH - 1);
        m_ridx  = (m_ridx + 1) % DEPTH;
      end
      return;
    end
    if (m_phase == P_IDLE || !se) return;
    m_hist.push_back(d);
    if (trig_edge)
      hit = (m_prev > trig_level) && (d <= trig_level);
    else
      hit = (m_prev < trig_level) && (d >= trig_level);
    m_prev = d;
    if (m_phase == P_PRE) begin
      m_cnt++;
      if (m_cnt == PRE) m_phase = P_ARMED;
    end else if (m_phase == P_ARMED) begin
      if (hit) begin
        m_phase = P_POST;
        m_cnt = 1;
      end
    end else begin
      m_cnt++;
    end
    if (m_phase == P_POST && m_cnt == DEPTH - PRE) begin
      m_phase = P_READ;
      m_ridx  = 0;
      for (int i = 0; i < DEPTH; i++)
        m_frame[i] = m_hist[m_hist.size() - DEPTH + i];
    end
  endfunction

  task automatic cyc(input bit a, input bit se, input bit re,
                     input logic [7:0] d);
    @(negedge in_clk);
    arm       = a;
    sample_en = se;
    resume_en = re;
    adc_data  = d;
    @(posedge in_clk);
    #1;
    model_step(a, se, re, d);
    arm       = 0;
    sample_en = 0;
    resume_en = 0;
  endtask

  // Drive-only: arm, fill pre-trigger, fire a rising trigger,
  // then npost further samples.
  task automatic fill_trig(input int npost);
    trig_level = 8'd128;
    trig_edge  = 1'b0;
    cyc(1, 0, 0, 0);
    repeat (PRE) cyc(0, 1, 0, 8'($urandom_range(0, 127)));
    repeat ($urandom_range(0, 5)) cyc(0, 1, 0, 8'($urandom_range(0, 127)));
    cyc(0, 1, 0, 8'($urandom_range(128, 255)));
    repeat (npost) cyc(0, 1, 0, 8'($urandom));
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge in_clk);
    #1;
    model_reset();
    total++;
    if (state !== 3'd0) begin
      bad++;
      $display("FAIL reset_state got=%0d want=0", state);
    end
    total++;
    if (dac_data !== 8'd0 || dac_valid !== 1'b0 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_outs got d=%0d v=%0b fd=%0b want 0/0/0",
               dac_data, dac_valid, frame_done);
    end
    @(negedge in_clk);
    reset = 0;
    repeat (4) cyc(0, 1, 1, 8'($urandom));
    total++;
    if (state !== 3'd0 || dac_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_ignore got st=%0d v=%0b want 0/0", state, dac_valid);
    end
  endtask

  task automatic test_capture();
    logic [7:0] pre_s[4]  = '{10, 20, 30, 40};
    logic [7:0] mid_s[5]  = '{50, 60, 5, 6, 7};
    logic [7:0] exp_f[16] = '{60, 5, 6, 7, 200, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
    logic [7:0] held;
    trig_level = 8'd100;
    trig_edge  = 1'b0;
    cyc(1, 0, 0, 0);
    total++;
    if (state !== 3'd1) begin
      bad++;
      $display("FAIL cap_arm got=%0d want=1", state);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, pre_s[i]);
      total++;
      if (state !== ((i == 3) ? 3'd2 : 3'd1)) begin
        bad++;
        $display("FAIL cap_pre%0d got=%0d want=%0d", i, state, (i == 3) ? 2 : 1);
      end
    end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, mid_s[i]);
      total++;
      if (state !== 3'd2) begin
        bad++;
        $display("FAIL cap_armed%0d got=%0d want=2", i, state);
      end
    end
    cyc(0, 1, 0, 8'd200);
    total++;
    if (state !== 3'd3) begin
      bad++;
      $display("FAIL cap_trig got=%0d want=3", state);
    end
    for (int i = 1; i <= 11; i++) begin
      cyc(0, 1, 0, 8'(i));
      total++;
      if (state !== ((i == 11) ? 3'd4 : 3'd3)) begin
        bad++;
        $display("FAIL cap_post%0d got=%0d want=%0d", i, state, (i == 11) ? 4 : 3);
      end
    end
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 0);
      total++;
      if (dac_valid !== 1'b1 || dac_data !== exp_f[i] ||
          frame_done !== (i == 15)) begin
        bad++;
        $display("FAIL cap_replay%0d got d=%0d v=%0b fd=%0b want d=%0d v=1 fd=%0b",
                 i, dac_data, dac_valid, frame_done, exp_f[i], i == 15);
      end
      total++;
      if (dac_data !== m_data) begin
        bad++;
        $display("FAIL cap_model%0d got=%0d want=%0d", i, dac_data, m_data);
      end
    end
    held = dac_data;
    cyc(0, 1, 0, 8'd99);
    total++;
    if (dac_valid !== 1'b0 || frame_done !== 1'b0 || dac_data !== 8'd11 ||
        state !== 3'd4) begin
      bad++;
      $display("FAIL cap_hold got d=%0d v=%0b fd=%0b st=%0d want d=11 v=0 fd=0 st=4 (prev %0d)",
               dac_data, dac_valid, frame_done, state, held);
    end
  endtask

  task automatic test_falling();
    logic [7:0] ramp[4] = '{90, 80, 70, 60};
    trig_level = 8'd50;
    trig_edge  = 1'b1;
    cyc(1, 0, 0, 0);
    repeat (PRE) cyc(0, 1, 0, 8'd100);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, ramp[i]);
      total++;
      if (state !== 3'd2) begin
        bad++;
        $display("FAIL fall_ramp%0d got=%0d want=2", i, state);
      end
    end
    cyc(0, 1, 0, 8'd50);
    total++;
    if (state !== 3'd3) begin
      bad++;
      $display("FAIL fall_trig got=%0d want=3", state);
    end
  endtask

  task automatic test_equal_level();
    int stuck = 0;
    trig_level = 8'd100;
    trig_edge  = 1'b0;
    cyc(1, 0, 0, 0);
    repeat (PRE) cyc(0, 1, 0, 8'd100);
    for (int i = 0; i < 100; i++) begin
      cyc(0, 1, 0, 8'd100);
      if (state == 3'd2) stuck++;
    end
    total++;
    if (stuck !== 100 || state !== 3'(m_phase)) begin
      bad++;
      $display("FAIL equal_level got armed_cycles=%0d st=%0d want 100/%0d",
               stuck, state, m_phase);
    end
  endtask

  task automatic test_replay_loop();
    logic [7:0] seen[40];
    int nvalid = 0;
    fill_trig(11);
    total++;
    if (state !== 3'd4) begin
      bad++;
      $display("FAIL loop_read got=%0d want=4", state);
    end
    for (int i = 0; i < 40; i++) begin
      cyc(0, $urandom_range(0, 1), 1, 8'($urandom));
      seen[i] = dac_data;
      if (dac_valid) nvalid++;
      total++;
      if (frame_done !== (i == 15 || i == 31) || dac_data !== m_data) begin
        bad++;
        $display("FAIL loop%0d got d=%0d fd=%0b want d=%0d fd=%0b",
                 i, dac_data, frame_done, m_data, i == 15 || i == 31);
      end
      if (i >= 16) begin
        total++;
        if (seen[i] !== seen[i-16]) begin
          bad++;
          $display("FAIL loop_period%0d got=%0d want=%0d", i, seen[i], seen[i-16]);
        end
      end
    end
    total++;
    if (nvalid !== 40) begin
      bad++;
      $display("FAIL loop_count got=%0d want=40", nvalid);
    end
  endtask

  task automatic test_arm_during_read();
    cyc(1, 0, 1, 0);
    total++;
    if (state !== 3'd1 || dac_valid !== 1'b0) begin
      bad++;
      $display("FAIL arm_read got st=%0d v=%0b want 1/0", state, dac_valid);
    end
    fill_trig(11);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 0);
      total++;
      if (dac_data !== m_data || dac_valid !== 1'b1 || frame_done !== m_fd) begin
        bad++;
        $display("FAIL rearm_replay%0d got d=%0d v=%0b fd=%0b want d=%0d v=1 fd=%0b",
                 i, dac_data, dac_valid, frame_done, m_data, m_fd);
      end
    end
  endtask

  task automatic test_reset_mid_post();
    fill_trig(5);
    total++;
    if (state !== 3'd3) begin
      bad++;
      $display("FAIL rpost_pre got=%0d want=3", state);
    end
    @(negedge in_clk);
    #5;
    reset = 1;
    #1;
    total++;
    if (state !== 3'd0 || dac_data !== 8'd0 || dac_valid !== 1'b0) begin
      bad++;
      $display("FAIL rpost_async got st=%0d d=%0d v=%0b want 0/0/0",
               state, dac_data, dac_valid);
    end
    @(negedge in_clk);
    reset = 0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 8'($urandom));
      total++;
      if (state !== 3'd0 || dac_valid !== 1'b0) begin
        bad++;
        $display("FAIL rpost_idle%0d got st=%0d v=%0b want 0/0", i, state, dac_valid);
      end
    end
  endtask

  task automatic test_random();
    bit a, se, re;
    for (int c = 0; c < 3000; c++) begin
      a  = ($urandom_range(0, 149) == 0);
      se = $urandom_range(0, 1);
      re = ($urandom_range(0, 2) != 0);
      if (a) begin
        trig_level = 8'($urandom);
        trig_edge  = $urandom_range(0, 1);
      end
      cyc(a, se, re, 8'($urandom));
      total++;
      if (state !== 3'(m_phase) || dac_valid !== m_valid ||
          frame_done !== m_fd || dac_data !== m_data) begin
        bad++;
        $display("FAIL rand c=%0d st=%0d/%0d v=%0b/%0b fd=%0b/%0b d=%0d/%0d",
                 c, state, m_phase, dac_valid, m_valid,
                 frame_done, m_fd, dac_data, m_data);
      end
    end
  endtask

  initial begin
    reset      = 1;
    sample_en  = 0;
    resume_en  = 0;
    arm        = 0;
    adc_data   = 0;
    trig_level = 0;
    trig_edge  = 0;
    model_reset();
    test_reset();
    test_capture();
    test_falling();
    test_equal_level();
    test_replay_loop();
    test_arm_during_read();
    test_reset_mid_post();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
